// File: rtl/tdc_arb_pkg.sv
// tdc_arb_pkg: shared definitions for the TDC FIFO readout arbiter.
//   - arb_state_t   : arbiter FSM encoding (IDLE, XFER)
//   - clog2()       : ceiling log2 used to size channel index fields
//   - DWIDTH_DEFAULT: default readout word width
//   - BURST_W       : width of the per-grant burst counter (MAX_BURST <= 255)
package tdc_arb_pkg;

    localparam int unsigned DWIDTH_DEFAULT = 32;
    localparam int unsigned BURST_W        = 8;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// rr_priority_select: combinational round-robin picker.
//   req     : request vector, one bit per channel
//   ptr     : channel with highest priority this round
//   grant   : first requesting channel at or after ptr, wrapping modulo NCH
//   any_req : at least one request bit is set (grant is only meaningful then)
module rr_priority_select import tdc_arb_pkg::*; #(
    parameter int unsigned NCH = 4,
    localparam int unsigned PW = clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [PW-1:0]  ptr,
    output logic [PW-1:0]  grant,
    output logic           any_req
);

    localparam logic [PW:0] NCH_W = (PW+1)'(NCH);

    logic [NCH-1:0] req_rot;
    logic [PW-1:0]  ffs_idx;
    logic [PW:0]    sum;

    assign any_req = |req;

    // Rotate so that channel ptr lands on bit 0.
    always_comb begin
        req_rot = NCH'({req, req} >> ptr);
    end

    // Find first set; scanning downward lets the lowest set bit win last.
    always_comb begin
        ffs_idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                ffs_idx = PW'(i);
            end
        end
    end

    // Rotate back: (ptr + ffs_idx) mod NCH, valid for non-power-of-two NCH.
    always_comb begin
        sum = {1'b0, ptr} + {1'b0, ffs_idx};
        if (sum >= NCH_W) begin
            sum = sum - NCH_W;
        end
        grant = sum[PW-1:0];
    end

endmodule

// File: rtl/tdc_fifo_arbiter.sv
// tdc_fifo_arbiter: merges NCH first-word-fall-through channel FIFOs into one
// ready/valid word stream, granting channels round-robin for bounded bursts.
//   FIFO_CLK  : sole clock
//   RST_N     : asynchronous active-low reset
//   CH_EN     : per-channel enable mask (disabled channels are never granted)
//   CH_EMPTY  : FWFT empty flags
//   CH_DATA   : FWFT data, channel i at [i*DWIDTH +: DWIDTH]
//   CH_READ   : combinational pop strobes, at most one bit high
//   OUT_DATA  : registered output word
//   OUT_VALID : OUT_DATA valid
//   OUT_READY : downstream accept
//   GRANT_ID  : current or last granted channel
//   BUSY      : arbiter is transferring a burst
//   WORD_CNT  : accepted output words, wraps modulo 2^16
module tdc_fifo_arbiter import tdc_arb_pkg::*; #(
    parameter int unsigned NCH       = 4,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned DWIDTH    = DWIDTH_DEFAULT,
    localparam int unsigned GW       = clog2(NCH)
) (
    input  logic                  FIFO_CLK,
    input  logic                  RST_N,
    input  logic [NCH-1:0]        CH_EN,
    input  logic [NCH-1:0]        CH_EMPTY,
    input  logic [NCH*DWIDTH-1:0] CH_DATA,
    output logic [NCH-1:0]        CH_READ,
    output logic [DWIDTH-1:0]     OUT_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [GW-1:0]         GRANT_ID,
    output logic                  BUSY,
    output logic [15:0]           WORD_CNT
);

    localparam logic [BURST_W-1:0] MAX_B   = BURST_W'(MAX_BURST);
    localparam logic [GW-1:0]      LAST_CH = GW'(NCH - 1);

    arb_state_t         state_q, state_d;
    logic [GW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]      grant_q, grant_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [DWIDTH-1:0]  out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic [15:0]        word_cnt_q, word_cnt_d;

    logic [NCH-1:0]     req;
    logic [GW-1:0]      sel_grant;
    logic               any_req;
    logic               slot_free;
    logic               pop;
    logic [DWIDTH-1:0]  ch_word [NCH];

    for (genvar i = 0; i < NCH; i++) begin : g_unpack
        assign ch_word[i] = CH_DATA[i*DWIDTH +: DWIDTH];
    end

    assign req       = CH_EN & ~CH_EMPTY;
    assign slot_free = !out_valid_q || OUT_READY;
    assign pop       = (state_q == XFER) && req[grant_q] && slot_free && (burst_cnt_q < MAX_B);

    rr_priority_select #(
        .NCH (NCH)
    ) u_rr_select (
        .req     (req),
        .ptr     (rr_ptr_q),
        .grant   (sel_grant),
        .any_req (any_req)
    );

    // The state register resets asynchronously to IDLE, so pop (and CH_READ)
    // is forced low for the whole time RST_N is asserted.
    always_comb begin
        CH_READ = '0;
        if (pop) begin
            CH_READ[grant_q] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d     = sel_grant;
                    burst_cnt_d = '0;
                    state_d     = XFER;
                end
            end
            XFER: begin
                if (pop) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
                // Leave on the same edge as the last allowed pop so the next
                // grant costs only a single IDLE cycle.
                if (!CH_EN[grant_q] || (CH_EMPTY[grant_q] && slot_free) ||
                    (burst_cnt_d >= MAX_B)) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_q == LAST_CH) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register is independent of the FSM state: a word pending at
    // grant exit stays valid until the downstream takes it.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        word_cnt_d  = word_cnt_q;
        if (pop) begin
            out_valid_d = 1'b1;
            out_data_d  = ch_word[grant_q];
        end else if (slot_free) begin
            out_valid_d = 1'b0;
        end
        if (out_valid_q && OUT_READY) begin
            word_cnt_d = word_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge FIFO_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            burst_cnt_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            burst_cnt_q <= burst_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign OUT_DATA  = out_data_q;
    assign OUT_VALID = out_valid_q;
    assign GRANT_ID  = grant_q;
    assign BUSY      = (state_q == XFER);
    assign WORD_CNT  = word_cnt_q;

endmodule

// File: tb/tb_tdc_fifo_arbiter.sv
// Testbench for tdc_fifo_arbiter: FWFT channel FIFOs modelled as queues, a
// cycle-level reference model of the arbitration rules, directed scenarios
// with literal expectations, and a randomized traffic phase.
module tb_tdc_fifo_arbiter;

    localparam int NCH  = 4;
    localparam int MAXB = 16;
    localparam int DW   = 32;

    logic              FIFO_CLK = 1'b0;
    logic              RST_N    = 1'b0;
    logic [NCH-1:0]    CH_EN    = '1;
    logic [NCH-1:0]    CH_EMPTY = '1;
    logic [NCH*DW-1:0] CH_DATA  = '0;
    logic [NCH-1:0]    CH_READ;
    logic [DW-1:0]     OUT_DATA;
    logic              OUT_VALID;
    logic              OUT_READY = 1'b1;
    logic [1:0]        GRANT_ID;
    logic              BUSY;
    logic [15:0]       WORD_CNT;

    tdc_fifo_arbiter #(
        .NCH       (NCH),
        .MAX_BURST (MAXB),
        .DWIDTH    (DW)
    ) dut (
        .FIFO_CLK  (FIFO_CLK),
        .RST_N     (RST_N),
        .CH_EN     (CH_EN),
        .CH_EMPTY  (CH_EMPTY),
        .CH_DATA   (CH_DATA),
        .CH_READ   (CH_READ),
        .OUT_DATA  (OUT_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .GRANT_ID  (GRANT_ID),
        .BUSY      (BUSY),
        .WORD_CNT  (WORD_CNT)
    );

    always #5 FIFO_CLK = ~FIFO_CLK;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(input string name, input logic [31:0] got,
                                input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    endfunction

    // Channel FIFOs; words are tagged {channel, sequence number}.
    logic [31:0] fifo_q [NCH][$];
    int          seq [NCH];

    // Logs written only by the monitor.
    int          pop_ch[$];
    int          pop_cyc[$];
    logic [31:0] acc_data[$];
    int          acc_cyc[$];
    logic [NCH-1:0] rd_s = '0;
    int          cyc = 0;

    // Reference model state.
    bit          m_busy;
    int          m_g, m_cnt, m_rr;
    bit          m_ov;
    logic [31:0] m_od;
    logic [15:0] m_wc;

    // Compare process: one pass per cycle at the falling edge.
    initial begin
        logic [NCH-1:0] req, exp_rd;
        bit free, exp_pop, picked;
        int c;
        m_busy = 0; m_g = 0; m_cnt = 0; m_rr = 0; m_ov = 0; m_od = '0; m_wc = '0;
        forever begin
            @(negedge FIFO_CLK);
            cyc++;
            if (!RST_N) begin
                chk("rst_ch_read", 32'(CH_READ), 32'd0);
                chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
                m_busy = 0; m_g = 0; m_cnt = 0; m_rr = 0; m_ov = 0; m_od = '0; m_wc = '0;
                rd_s = '0;
            end else begin
                req     = CH_EN & ~CH_EMPTY;
                free    = !m_ov || OUT_READY;
                exp_pop = m_busy && req[m_g] && free && (m_cnt < MAXB);
                exp_rd  = exp_pop ? NCH'(1 << m_g) : '0;
                chk("ch_read", 32'(CH_READ), 32'(exp_rd));
                chk("out_valid", 32'(OUT_VALID), 32'(m_ov));
                if (m_ov) chk("out_data", OUT_DATA, m_od);
                chk("grant_id", 32'(GRANT_ID), 32'(m_g));
                chk("busy", 32'(BUSY), 32'(m_busy));
                chk("word_cnt", 32'(WORD_CNT), 32'(m_wc));
                rd_s = CH_READ;
                for (int i = 0; i < NCH; i++) begin
                    if (CH_READ[i]) begin pop_ch.push_back(i); pop_cyc.push_back(cyc); end
                end
                if (OUT_VALID && OUT_READY) begin
                    acc_data.push_back(OUT_DATA); acc_cyc.push_back(cyc);
                end
                // Advance the model by one clock edge.
                if (m_ov && OUT_READY) m_wc = m_wc + 16'd1;
                if (exp_pop) begin
                    m_od = fifo_q[m_g][0]; m_ov = 1; m_cnt++;
                end else if (free) begin
                    m_ov = 0;
                end
                if (m_busy) begin
                    if (!CH_EN[m_g] || (CH_EMPTY[m_g] && free) || m_cnt >= MAXB) begin
                        m_busy = 0; m_rr = (m_g + 1) % NCH;
                    end
                end else if (req != '0) begin
                    picked = 0;
                    for (int k = 0; k < NCH; k++) begin
                        c = (m_rr + k) % NCH;
                        if (req[c] && !picked) begin m_g = c; picked = 1; end
                    end
                    m_cnt = 0; m_busy = 1;
                end
            end
        end
    end

    task automatic refresh();
        for (int i = 0; i < NCH; i++) begin
            CH_EMPTY[i] = (fifo_q[i].size() == 0);
            CH_DATA[i*DW +: DW] = (fifo_q[i].size() != 0) ? fifo_q[i][0] : 32'h0;
        end
    endtask

    task automatic push(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            fifo_q[ch].push_back({8'(ch), 24'(seq[ch])});
            seq[ch]++;
        end
        refresh();
    endtask

    // Advance one cycle; leaves time at posedge+1 with popped FIFOs updated.
    task automatic tick();
        logic [31:0] tmp;
        @(posedge FIFO_CLK);
        #1;
        for (int i = 0; i < NCH; i++) begin
            if (rd_s[i] && fifo_q[i].size() > 0) tmp = fifo_q[i].pop_front();
        end
        refresh();
    endtask

    task automatic do_reset();
        @(posedge FIFO_CLK);
        #3 RST_N = 1'b0;
        for (int i = 0; i < NCH; i++) fifo_q[i].delete();
        refresh();
        repeat (2) @(posedge FIFO_CLK);
        #1 RST_N = 1'b1;
    endtask

    task automatic drain(input int max_cyc);
        bit done;
        done = 0;
        for (int k = 0; k < max_cyc && !done; k++) begin
            tick();
            done = !OUT_VALID && !BUSY && ((CH_EN & ~CH_EMPTY) == '0);
        end
        chk("drain_done", 32'(done), 32'd1);
    endtask

    // Group pops since index base into runs of consecutive cycles on one channel.
    int run_ch[$], run_len[$], run_first[$], run_last[$];
    task automatic get_runs(input int base);
        int n;
        run_ch.delete(); run_len.delete(); run_first.delete(); run_last.delete();
        for (int k = base; k < pop_ch.size(); k++) begin
            n = run_ch.size();
            if (n == 0 || pop_ch[k] != run_ch[n-1] || pop_cyc[k] != run_last[n-1] + 1) begin
                run_ch.push_back(pop_ch[k]); run_len.push_back(1);
                run_first.push_back(pop_cyc[k]); run_last.push_back(pop_cyc[k]);
            end else begin
                run_len[n-1] = run_len[n-1] + 1;
                run_last[n-1] = pop_cyc[k];
            end
        end
    endtask

    initial begin
        logic [NCH-1:0] hist [8];
        bit pat [5];
        int pb, ab, cnt, s0, pushed;
        int exp_seq [NCH];
        logic [31:0] w;
        for (int i = 0; i < NCH; i++) seq[i] = 0;

        // Reset values.
        do_reset();
        chk("rv_out_valid", 32'(OUT_VALID), 32'd0);
        chk("rv_out_data", OUT_DATA, 32'd0);
        chk("rv_grant", 32'(GRANT_ID), 32'd0);
        chk("rv_busy", 32'(BUSY), 32'd0);
        chk("rv_word_cnt", 32'(WORD_CNT), 32'd0);

        // A: ch2 with 5 words, ready held high.
        ab = acc_data.size();
        push(2, 5);
        for (int k = 0; k < 7; k++) begin tick(); hist[k] = rd_s; end
        chk("a_rd0", 32'(hist[0]), 32'h0);
        for (int k = 1; k <= 5; k++) chk("a_rd_burst", 32'(hist[k]), 32'h4);
        chk("a_rd6", 32'(hist[6]), 32'h0);
        drain(20);
        chk("a_grant", 32'(GRANT_ID), 32'd2);
        chk("a_word_cnt", 32'(WORD_CNT), 32'd5);
        chk("a_nacc", acc_data.size() - ab, 32'd5);
        for (int k = 0; k < 5 && ab + k < acc_data.size(); k++) begin
            chk("a_word", acc_data[ab+k], 32'h0200_0000 + k);
            if (k > 0) chk("a_b2b", acc_cyc[ab+k], acc_cyc[ab+k-1] + 1);
        end

        // B: all channels full, 40 words each.
        do_reset();
        pb = pop_ch.size();
        for (int i = 0; i < NCH; i++) push(i, 40);
        drain(400);
        get_runs(pb);
        chk("b_nruns", run_ch.size(), 32'd12);
        for (int r = 0; r < 12 && r < run_ch.size(); r++) begin
            chk("b_run_ch", run_ch[r], r % 4);
            chk("b_run_len", run_len[r], (r < 8) ? 16 : 8);
        end
        chk("b_word_cnt", 32'(WORD_CNT), 32'd160);

        // C: backpressure on ch0 with 3 words.
        do_reset();
        ab = acc_data.size();
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        s0 = seq[0];
        OUT_READY = 1'b1;
        push(0, 3);
        for (int k = 0; k < 7; k++) begin
            tick(); hist[k] = rd_s;
            if (k == 1 || k == 2) chk("c_hold", OUT_DATA, 32'(s0));
            OUT_READY = (k < 5) ? pat[k] : 1'b1;
        end
        chk("c_rd0", 32'(hist[0]), 32'h0); chk("c_rd1", 32'(hist[1]), 32'h1);
        chk("c_rd2", 32'(hist[2]), 32'h0); chk("c_rd3", 32'(hist[3]), 32'h0);
        chk("c_rd4", 32'(hist[4]), 32'h1); chk("c_rd5", 32'(hist[5]), 32'h1);
        drain(20);
        chk("c_word_cnt", 32'(WORD_CNT), 32'd3);
        for (int k = 0; k < 3 && ab + k < acc_data.size(); k++)
            chk("c_word", acc_data[ab+k], 32'(s0 + k));

        // D: CH_EN[1] cleared after 4 pops from ch1.
        do_reset();
        pb = pop_ch.size();
        push(1, 10); push(2, 3);
        cnt = 0;
        for (int k = 0; k < 20 && cnt < 4; k++) begin tick(); if (rd_s[1]) cnt++; end
        CH_EN[1] = 1'b0;
        drain(40);
        cnt = 0; s0 = 0;
        for (int k = pb; k < pop_ch.size(); k++) begin
            if (pop_ch[k] == 1) cnt++;
            if (pop_ch[k] == 2) s0++;
        end
        chk("d_ch1_pops", cnt, 32'd4);
        chk("d_ch2_pops", s0, 32'd3);
        chk("d_ch1_left", fifo_q[1].size(), 32'd6);
        chk("d_grant", 32'(GRANT_ID), 32'd2);
        chk("d_word_cnt", 32'(WORD_CNT), 32'd7);
        CH_EN = '1;

        // E: reset mid-burst with a valid word registered.
        do_reset();
        push(2, 3);
        drain(20);
        push(2, 10);
        for (int k = 0; k < 10 && !OUT_VALID; k++) tick();
        chk("e_pre_valid", 32'(OUT_VALID), 32'd1);
        chk("e_pre_grant", 32'(GRANT_ID), 32'd2);
        push(0, 2); push(3, 2);
        pb = pop_ch.size();
        #2 RST_N = 1'b0;
        #1;
        chk("e_async_valid", 32'(OUT_VALID), 32'd0);
        chk("e_async_cnt", 32'(WORD_CNT), 32'd0);
        chk("e_async_grant", 32'(GRANT_ID), 32'd0);
        chk("e_async_busy", 32'(BUSY), 32'd0);
        repeat (2) @(posedge FIFO_CLK);
        #1 RST_N = 1'b1;
        drain(60);
        chk("e_first_ch", (pop_ch.size() > pb) ? pop_ch[pb] : -1, 32'd0);

        // F: rr pointer wrap with only ch3 and ch0 requesting.
        do_reset();
        push(2, 2);
        drain(20);
        pb = pop_ch.size();
        push(0, 32); push(3, 32);
        drain(200);
        get_runs(pb);
        chk("f_nruns", run_ch.size(), 32'd4);
        for (int r = 0; r < 4 && r < run_ch.size(); r++) begin
            chk("f_run_ch", run_ch[r], (r % 2 == 0) ? 3 : 0);
            chk("f_run_len", run_len[r], 32'd16);
            if (r > 0) chk("f_gap", run_first[r] - run_last[r-1], 32'd2);
        end

        // Random traffic, enables and backpressure.
        do_reset();
        ab = acc_data.size();
        pushed = 0;
        for (int i = 0; i < NCH; i++) exp_seq[i] = seq[i];
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                cnt = $urandom_range(1, 6);
                push($urandom_range(0, NCH - 1), cnt);
                pushed += cnt;
            end
            if ($urandom_range(0, 39) == 0) begin
                s0 = $urandom_range(0, NCH - 1);
                CH_EN[s0] = ~CH_EN[s0];
            end
            OUT_READY = ($urandom_range(0, 3) != 0);
            tick();
        end
        CH_EN = '1;
        OUT_READY = 1'b1;
        drain(2000);
        chk("r_delivered", acc_data.size() - ab, pushed);
        cnt = 0;
        for (int k = ab; k < acc_data.size(); k++) begin
            w = acc_data[k];
            if (w[23:0] != 24'(exp_seq[w[31:24]])) cnt++;
            exp_seq[w[31:24]]++;
        end
        chk("r_order_errors", cnt, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
